// File: rtl/frame_tx_scheduler.sv
// rtl/frame_tx_scheduler.sv - segment/clone sequencer driving the UDP frame generator
// Optional start-acknowledge watchdog with retry counter: define SCHED_TIMEOUT_EN.
module frame_tx_scheduler #(
  parameter int CLONES     = 3,
  parameter int GAP_CYCLES = 24,
  parameter int MAX_ADDR   = 57600
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_req,
  input  logic        gen_busy,
  input  logic [19:0] gen_lastaddr,
  output logic        gen_start,
  output logic [19:0] startaddr,
  output logic [7:0]  index_clone,
  output logic [15:0] segment_num,
  output logic [7:0]  aux,
  output logic        sched_busy,
  output logic        frame_done,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_NEXT
  } state_t;

  localparam int              GW         = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_CYCLES);
  localparam logic [7:0]      LAST_CLONE = 8'(CLONES - 1);
  localparam logic [19:0]     MAX_A      = 20'(MAX_ADDR);

  state_t        state_q, state_d;
  logic          gen_start_q, gen_start_d;
  logic [19:0]   startaddr_q, startaddr_d;
  logic [7:0]    index_clone_q, index_clone_d;
  logic [15:0]   segment_num_q, segment_num_d;
  logic [7:0]    aux_q, aux_d;
  logic          frame_done_q, frame_done_d;
  logic [19:0]   last_q, last_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          timeout_hit;

`ifdef SCHED_TIMEOUT_EN
  // WAIT_BUSY cycles plus the ARM cycle make up the TIMEOUT window, so the retry
  // start lands exactly TIMEOUT cycles after the unanswered one.
  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

  logic [TW-1:0] to_cnt_q;
  logic [7:0]    err_count_q;

  assign timeout_hit = (state_q == S_WAIT_BUSY) && !gen_busy && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q    <= '0;
      err_count_q <= 8'd0;
    end else if (state_q == S_WAIT_BUSY && !gen_busy) begin
      if (timeout_hit) begin
        to_cnt_q <= '0;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign err_count = err_count_q;
`else
  assign timeout_hit = 1'b0;
  assign err_count   = 8'd0;
`endif

  always_comb begin
    state_d       = state_q;
    gen_start_d   = 1'b0;
    startaddr_d   = startaddr_q;
    index_clone_d = index_clone_q;
    segment_num_d = segment_num_q;
    aux_d         = aux_q;
    frame_done_d  = 1'b0;
    last_d        = last_q;
    gap_cnt_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_req && enable) begin
          startaddr_d   = 20'd0;
          segment_num_d = 16'd0;
          index_clone_d = 8'd0;
          state_d       = S_ARM;
        end
      end
      S_ARM: begin
        // The generator is never reset by us, so wait for it to be idle.
        if (!gen_busy) begin
          gen_start_d = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (gen_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d = S_ARM;
        end
      end
      S_WAIT_DONE: begin
        if (!gen_busy) begin
          last_d  = gen_lastaddr;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (index_clone_q < LAST_CLONE) begin
          index_clone_d = index_clone_q + 8'd1;
          state_d       = S_ARM;
        end else if (last_q == 20'd0 || last_q >= MAX_A) begin
          // lastaddr 0 means the generator wrapped past the end of VRAM.
          frame_done_d  = 1'b1;
          aux_d         = aux_q + 8'd1;
          index_clone_d = 8'd0;
          state_d       = S_IDLE;
        end else begin
          startaddr_d   = last_q + 20'd1;
          segment_num_d = segment_num_q + 16'd1;
          index_clone_d = 8'd0;
          state_d       = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gen_start_q   <= 1'b0;
      startaddr_q   <= 20'd0;
      index_clone_q <= 8'd0;
      segment_num_q <= 16'd0;
      aux_q         <= 8'd0;
      frame_done_q  <= 1'b0;
      last_q        <= 20'd0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      gen_start_q   <= gen_start_d;
      startaddr_q   <= startaddr_d;
      index_clone_q <= index_clone_d;
      segment_num_q <= segment_num_d;
      aux_q         <= aux_d;
      frame_done_q  <= frame_done_d;
      last_q        <= last_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign gen_start   = gen_start_q;
  assign startaddr   = startaddr_q;
  assign index_clone = index_clone_q;
  assign segment_num = segment_num_q;
  assign aux         = aux_q;
  assign frame_done  = frame_done_q;
  assign sched_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb/tb_frame_tx_scheduler.sv - directed bench for frame_tx_scheduler
// Plays the frame generator by hand; timeout section needs SCHED_TIMEOUT_EN.
module tb_frame_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, frame_req, gen_busy;
  logic [19:0] gen_lastaddr;
  logic        gen_start, sched_busy, frame_done;
  logic [19:0] startaddr;
  logic [7:0]  index_clone, aux, err_count;
  logic [15:0] segment_num;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_fall = -1;
  int n_starts = 0;
  int fd_cnt = 0;
  int viol = 0;

  frame_tx_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .frame_req    (frame_req),
    .gen_busy     (gen_busy),
    .gen_lastaddr (gen_lastaddr),
    .gen_start    (gen_start),
    .startaddr    (startaddr),
    .index_clone  (index_clone),
    .segment_num  (segment_num),
    .aux          (aux),
    .sched_busy   (sched_busy),
    .frame_done   (frame_done),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gen_start) n_starts <= n_starts + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (gen_start && gen_busy) viol <= viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (gen_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  // One generator frame: wait for start, check the segment fields, busy for 5 cycles.
  task automatic serve(input string tag, input logic [19:0] sa, input logic [7:0] ic,
                       input logic [15:0] seg, input logic [19:0] last, input bit drop_en);
    bit ok;
    wait_start(120, ok);
    chk({tag, " start"}, 32'(ok), 32'd1);
    if (!ok) return;
    chk({tag, " startaddr"}, 32'(startaddr), 32'(sa));
    chk({tag, " index_clone"}, 32'(index_clone), 32'(ic));
    chk({tag, " segment_num"}, 32'(segment_num), 32'(seg));
    if (t_fall >= 0) chk({tag, " gap"}, 32'(cyc >= t_fall + 26), 32'd1);
    tick();
    gen_busy     = 1'b1;
    gen_lastaddr = 20'hABCDE;
    for (int i = 0; i < 5; i++) begin
      if (drop_en && i == 1) begin
        enable    = 1'b0;
        frame_req = 1'b1;
      end
      if (drop_en && i == 2) frame_req = 1'b0;
      tick();
    end
    chk({tag, " sa_hold"}, 32'(startaddr), 32'(sa));
    gen_busy     = 1'b0;
    gen_lastaddr = last;
    t_fall       = cyc;
  endtask

  initial begin
    bit ok;
    int n0;
    rst          = 1'b1;
    enable       = 1'b1;
    frame_req    = 1'b0;
    gen_busy     = 1'b0;
    gen_lastaddr = 20'd0;
    tick(); tick(); tick();
    rst = 1'b0;

    chk("rst gen_start", 32'(gen_start), 32'd0);
    chk("rst startaddr", 32'(startaddr), 32'd0);
    chk("rst index_clone", 32'(index_clone), 32'd0);
    chk("rst segment_num", 32'(segment_num), 32'd0);
    chk("rst aux", 32'(aux), 32'd0);
    chk("rst sched_busy", 32'(sched_busy), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);

    // Frame 1: three segments, earlier clones report misleading lastaddr values.
    pulse_req();
    chk("lat1 gen_start", 32'(gen_start), 32'd0);
    chk("lat1 sched_busy", 32'(sched_busy), 32'd1);
    tick();
    chk("lat2 gen_start", 32'(gen_start), 32'd1);
    serve("f1s0c0", 20'd0,   8'd0, 16'd0, 20'd0,     1'b0);
    serve("f1s0c1", 20'd0,   8'd1, 16'd0, 20'd57600, 1'b0);
    serve("f1s0c2", 20'd0,   8'd2, 16'd0, 20'd359,   1'b0);
    serve("f1s1c0", 20'd360, 8'd0, 16'd1, 20'd0,     1'b0);
    serve("f1s1c1", 20'd360, 8'd1, 16'd1, 20'd57600, 1'b0);
    serve("f1s1c2", 20'd360, 8'd2, 16'd1, 20'd719,   1'b0);
    serve("f1s2c0", 20'd720, 8'd0, 16'd2, 20'd500,   1'b0);
    serve("f1s2c1", 20'd720, 8'd1, 16'd2, 20'd500,   1'b0);
    serve("f1s2c2", 20'd720, 8'd2, 16'd2, 20'd0,     1'b0);
    wait_done(60, ok);
    chk("f1 frame_done", 32'(ok), 32'd1);
    chk("f1 aux", 32'(aux), 32'd1);
    chk("f1 idle", 32'(sched_busy), 32'd0);
    tick();
    chk("f1 done_pulse", 32'(frame_done), 32'd0);
    chk("f1 done_count", 32'(fd_cnt), 32'd1);
    chk("f1 start_count", 32'(n_starts), 32'd9);

    // Frame 2: lastaddr == MAX_ADDR ends the video frame.
    pulse_req();
    serve("f2c0", 20'd0, 8'd0, 16'd0, 20'd100,   1'b0);
    serve("f2c1", 20'd0, 8'd1, 16'd0, 20'd100,   1'b0);
    serve("f2c2", 20'd0, 8'd2, 16'd0, 20'd57600, 1'b0);
    wait_done(60, ok);
    chk("f2 frame_done", 32'(ok), 32'd1);
    chk("f2 aux", 32'(aux), 32'd2);
    chk("f2 idle", 32'(sched_busy), 32'd0);

    // Frame 3: reset while the generator is busy.
    pulse_req();
    wait_start(20, ok);
    chk("f3 start", 32'(ok), 32'd1);
    tick();
    gen_busy = 1'b1;
    tick(); tick();
    chk("f3 busy_pre_rst", 32'(sched_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst gen_start", 32'(gen_start), 32'd0);
    chk("mrst startaddr", 32'(startaddr), 32'd0);
    chk("mrst index_clone", 32'(index_clone), 32'd0);
    chk("mrst segment_num", 32'(segment_num), 32'd0);
    chk("mrst aux", 32'(aux), 32'd0);
    chk("mrst sched_busy", 32'(sched_busy), 32'd0);
    chk("mrst frame_done", 32'(frame_done), 32'd0);
    chk("mrst err_count", 32'(err_count), 32'd0);
    pulse_req();
    n0 = n_starts;
    for (int i = 0; i < 10; i++) tick();
    chk("arm hold no_start", 32'(n_starts - n0), 32'd0);
    chk("arm hold busy", 32'(sched_busy), 32'd1);
    gen_busy = 1'b0;
    t_fall   = -1;

    // Enable dropped during segment 1; frame_req while busy is ignored.
    serve("f4s0c0", 20'd0,   8'd0, 16'd0, 20'd5,   1'b0);
    serve("f4s0c1", 20'd0,   8'd1, 16'd0, 20'd0,   1'b0);
    serve("f4s0c2", 20'd0,   8'd2, 16'd0, 20'd359, 1'b0);
    serve("f4s1c0", 20'd360, 8'd0, 16'd1, 20'd719, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!sched_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("en_drop idle", 32'(ok), 32'd1);
    chk("en_drop no_done", 32'(fd_cnt), 32'd2);
    chk("en_drop aux", 32'(aux), 32'd0);
    chk("en_drop segment_num", 32'(segment_num), 32'd1);
    n0 = n_starts;
    for (int i = 0; i < 40; i++) tick();
    chk("en_drop req_ignored", 32'(n_starts - n0), 32'd0);
    chk("en_drop still_idle", 32'(sched_busy), 32'd0);

`ifdef SCHED_TIMEOUT_EN
    begin
      int s0;
      enable = 1'b1;
      pulse_req();
      wait_start(20, ok);
      chk("to first_start", 32'(ok), 32'd1);
      s0 = cyc;
      tick();
      wait_start(100, ok);
      chk("to retry_start", 32'(ok), 32'd1);
      chk("to retry_delay", 32'(cyc - s0), 32'd64);
      chk("to retry_startaddr", 32'(startaddr), 32'd0);
      chk("to retry_index", 32'(index_clone), 32'd0);
      chk("to err_count1", 32'(err_count), 32'd1);
      for (int k = 0; k < 254; k++) begin
        tick();
        wait_start(100, ok);
        if (!ok) begin
          chk("to retry_loop", 32'(ok), 32'd1);
          break;
        end
      end
      chk("to err_count255", 32'(err_count), 32'd255);
      tick();
      wait_start(100, ok);
      chk("to sat_start", 32'(ok), 32'd1);
      chk("to err_sat", 32'(err_count), 32'd255);
    end
`else
    chk("err_count tied", 32'(err_count), 32'd0);
`endif

    chk("start_while_busy", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
Sequences the UDP frame generator that streams VRAM pixel bytes into Ethernet frames. Each video frame is split into consecutive VRAM segments, and each segment is sent CLONES times for redundancy. The block drives startaddr, index_clone, segment_num and aux, pulses the generator's start input, tracks its busy/lastaddr outputs, and enforces an inter-frame gap. It sits between the video-frame trigger and the frame generator, upstream of the MAC/CRC path.

Parameters:
CLONES, 3, copies sent per segment (1..255)
GAP_CYCLES, 24, idle cycles after busy falls before the next start (>=1)
MAX_ADDR, 57600, last valid VRAM word address of a video frame
TIMEOUT, 64, cycles allowed for busy to rise after start (watchdog feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  0 = finish the current generator frame, then park in IDLE
frame_req  in  1  1-cycle pulse: new video frame ready in VRAM
gen_busy  in  1  generator busy
gen_lastaddr  in  20  generator last VRAM address used; valid once busy falls; 0 = wrapped past end
gen_start  out  1  1-cycle start pulse to generator
startaddr  out  20  segment start address
index_clone  out  8  clone index 0..CLONES-1
segment_num  out  16  segment number within the video frame
aux  out  8  video frame counter, wraps 255->0
sched_busy  out  1  high while not IDLE
frame_done  out  1  1-cycle pulse after the last clone of the last segment completes
err_count  out  8  watchdog retries, saturating (0 when feature is absent)

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset takes effect on any cycle, including mid-frame. The generator is not reset by this block; the next start is issued only after gen_busy is seen low.
- States: IDLE, ARM, WAIT_BUSY, WAIT_DONE, GAP, NEXT.
- IDLE: on frame_req && enable:
  - startaddr=0, segment_num=0, index_clone=0.
  - Go to ARM. frame_req seen in any other state is ignored (not queued).
- ARM:
  - If gen_busy=0, assert gen_start for exactly one cycle, then go to WAIT_BUSY.
  - Otherwise hold in ARM.
- WAIT_BUSY: on gen_busy=1, go to WAIT_DONE.
- WAIT_DONE: on gen_busy 1->0, capture gen_lastaddr into last_r, then go to GAP.
- GAP:
  - Count GAP_CYCLES cycles. The count starts on the cycle after entry.
  - Exit to NEXT on the cycle the count reaches GAP_CYCLES.
- NEXT (1 cycle):
  - If index_clone < CLONES-1: index_clone+1, go to ARM (startaddr unchanged).
  - Else if last_r==0 or last_r>=MAX_ADDR: end of video frame. Pulse frame_done, aux+1, index_clone=0, go to IDLE.
  - Else: startaddr=last_r+1, segment_num+1, index_clone=0, go to ARM.
  - If enable=0 on entry to NEXT: go to IDLE with no frame_done pulse; aux and segment_num hold.
- Ordering: startaddr and index_clone are stable from the ARM entry cycle until WAIT_DONE exits. The generator samples them while busy.
- Only the last clone's gen_lastaddr determines segment advance. Earlier captures are overwritten.
- segment_num wraps 65535->0. Its adder width is 16 bits; the startaddr adder is 20 bits.
- gen_start is never asserted while gen_busy=1.
- Latency: frame_req to gen_start is 2 cycles when the generator is idle.

Optional Feature:
Macro SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_BUSY counts cycles. If gen_busy stays 0 for TIMEOUT cycles, return to ARM and re-pulse start with the same startaddr and index_clone.
  - err_count increments, saturating at 255.
  - rst clears the counter and err_count.
- Not defined:
  - WAIT_BUSY waits indefinitely.
  - err_count is tied to 0.
  - No counter logic is synthesised.

Test Plan:
- CLONES=3, generator model returns lastaddr 359, 719, 0 -> 9 start pulses; startaddr sequence 0,0,0,360,360,360,720,720,720; index_clone 0,1,2 repeating; segment_num 0,1,2; one frame_done; aux=1.
- busy falls at cycle T with GAP_CYCLES=24 -> next gen_start not before T+26; gen_start never coincides with busy=1.
- gen_lastaddr=57600 on the last clone -> frame_done, IDLE; a second frame_req restarts at startaddr=0 with aux=2.
- rst asserted mid-WAIT_DONE while busy=1 -> all outputs 0 next cycle; a following frame_req does not pulse gen_start until busy=0.
- enable dropped during segment 1 -> current generator frame completes, IDLE with no frame_done, aux unchanged; frame_req during WAIT_DONE ignored.
- SCHED_TIMEOUT_EN, TIMEOUT=64, busy held 0 -> re-start pulse 64 cycles after first, err_count=1; same startaddr; saturates at 255.
